cnn_input_loader: RTL and testbench



---
 rtl/cnn_pkg.sv | 52 +++++
 rtl/cnn_window_sel.sv | 20 ++
 rtl/cnn_input_loader.sv | 149 ++++++++++++++
 tb/tb_cnn_input_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, types and tap-index helper for the CNN input loader.
// Define CNN_LOADER_ZPAD_EN for "same" zero-padded windows centred on every pixel.
package cnn_pkg;

    localparam int DATA_W  = 15;
    localparam int IMG_W   = 6;
    localparam int K       = 3;
    localparam int NUM_PIX = IMG_W * IMG_W;
    localparam int NUM_W   = K * K;

`ifdef CNN_LOADER_ZPAD_EN
    localparam int PAD_OFF = K / 2;
    localparam int SIDE    = IMG_W;
`else
    localparam int PAD_OFF = 0;
    localparam int SIDE    = IMG_W - K + 1;
`endif

    localparam int NUM_WIN   = SIDE * SIDE;
    localparam int PIX_CNT_W = $clog2(NUM_PIX + 1);
    localparam int W_CNT_W   = $clog2(NUM_W + 1);
    localparam int PIX_IDX_W = $clog2(NUM_PIX);

    typedef logic [PIX_CNT_W-1:0] pix_cnt_t;
    typedef logic [W_CNT_W-1:0]   w_cnt_t;
    typedef logic [PIX_IDX_W-1:0] pix_idx_t;
    typedef logic [2:0]           pos_t;

    localparam pix_cnt_t PIX_FULL = pix_cnt_t'(NUM_PIX);
    localparam w_cnt_t   W_FULL   = w_cnt_t'(NUM_W);
    localparam pos_t     POS_MAX  = pos_t'(SIDE - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStream} load_state_e;

    typedef struct packed {
        logic     pad;
        pix_idx_t idx;
    } tap_t;

    // Maps window position plus tap offset to a raster index; off-image taps flag pad.
    function automatic tap_t tap_index(pos_t row, pos_t col, int r, int c);
        tap_t t;
        int   pr;
        int   pc;
        pr    = int'(row) + r - PAD_OFF;
        pc    = int'(col) + c - PAD_OFF;
        t.pad = (pr < 0) || (pr >= IMG_W) || (pc < 0) || (pc >= IMG_W);
        t.idx = t.pad ? '0 : pix_idx_t'(pr * IMG_W + pc);
        return t;
    endfunction

endpackage

// File: rtl/cnn_window_sel.sv
// Combinational KxK window extraction from the flat image buffer.
// Padding behaviour follows CNN_LOADER_ZPAD_EN via cnn_pkg::tap_index.
module cnn_window_sel
    import cnn_pkg::*;
(
    input  logic [DATA_W-1:0]     img [NUM_PIX],
    input  logic [2:0]            row,
    input  logic [2:0]            col,
    output logic [K*K*DATA_W-1:0] win
);

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            tap_t tap;
            assign tap = tap_index(row, col, r, c);
            assign win[(r*K+c)*DATA_W +: DATA_W] = tap.pad ? '0 : img[tap.idx];
        end
    end

endmodule

// File: rtl/cnn_input_loader.sv
// Captures image and kernel streams, then streams every window with the kernel.
// CNN_LOADER_ZPAD_EN selects "same" zero-padded windows instead of valid-only.
module cnn_input_loader
    import cnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_1,
    input  logic                  in_valid_2,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [K*K*DATA_W-1:0] win_data,
    output logic [K*K*DATA_W-1:0] kern_data,
    output logic [2:0]            win_row,
    output logic [2:0]            win_col,
    output logic                  win_last,
    output logic                  busy,
    output logic                  err_proto
);

    load_state_e           state_q, state_d;
    pix_cnt_t              pix_cnt_q, pix_cnt_d;
    w_cnt_t                w_cnt_q, w_cnt_d;
    logic [DATA_W-1:0]     img_q [NUM_PIX];
    logic [DATA_W-1:0]     kern_q [NUM_W];
    pos_t                  row_q, row_d, col_q, col_d;
    logic                  valid_q, valid_d, last_q, last_d;
    logic                  err_q, err_d, busy_q, busy_d;
    logic [K*K*DATA_W-1:0] win_q, sel_win;
    logic                  load_win, pix_we, w_we;

    // Fed with the next position so the window register loads alongside row/col.
    cnn_window_sel u_window_sel (
        .img (img_q),
        .row (row_d),
        .col (col_d),
        .win (sel_win)
    );

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        w_cnt_d   = w_cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        valid_d   = valid_q;
        last_d    = last_q;
        err_d     = 1'b0;
        load_win  = 1'b0;
        pix_we    = 1'b0;
        w_we      = 1'b0;
        unique case (state_q)
            StIdle, StLoad: begin
                if (in_valid_1 || in_valid_2) state_d = StLoad;
                if (in_valid_1 && in_valid_2) begin
                    err_d = 1'b1;
                end else if (in_valid_1) begin
                    if (pix_cnt_q == PIX_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        pix_we    = 1'b1;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end else if (in_valid_2) begin
                    if (w_cnt_q == W_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        w_we    = 1'b1;
                        w_cnt_d = w_cnt_q + 1'b1;
                    end
                end
                if (pix_cnt_d == PIX_FULL && w_cnt_d == W_FULL) state_d = StStream;
            end
            StStream: begin
                err_d = in_valid_1 || in_valid_2;
                if (!valid_q) begin
                    load_win = 1'b1;
                    valid_d  = 1'b1;
                    last_d   = (row_q == POS_MAX) && (col_q == POS_MAX);
                end else if (win_ready) begin
                    if (last_q) begin
                        state_d   = StIdle;
                        valid_d   = 1'b0;
                        last_d    = 1'b0;
                        row_d     = '0;
                        col_d     = '0;
                        pix_cnt_d = '0;
                        w_cnt_d   = '0;
                    end else begin
                        if (col_q == POS_MAX) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        load_win = 1'b1;
                        last_d   = (row_d == POS_MAX) && (col_d == POS_MAX);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pix_cnt_q <= '0;
            w_cnt_q   <= '0;
            img_q     <= '{default: '0};
            kern_q    <= '{default: '0};
            row_q     <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            w_cnt_q   <= w_cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            if (pix_we)   img_q[pix_cnt_q[PIX_IDX_W-1:0]] <= in_data;
            if (w_we)     kern_q[w_cnt_q] <= in_data;
            if (load_win) win_q <= sel_win;
        end
    end

    for (genvar i = 0; i < NUM_W; i++) begin : g_kern
        assign kern_data[i*DATA_W +: DATA_W] = kern_q[i];
    end

    assign win_valid = valid_q;
    assign win_data  = win_q;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign win_last  = last_q;
    assign busy      = busy_q;
    assign err_proto = err_q;

endmodule

// File: tb/tb_cnn_input_loader.sv
// Self-checking bench for cnn_input_loader: window model plus directed literal checks.
// Honours CNN_LOADER_ZPAD_EN to match the padded build.
`timescale 1ns/1ps
module tb_cnn_input_loader;

    localparam int DW = 15;
    localparam int IW = 6;
    localparam int KS = 3;
`ifdef CNN_LOADER_ZPAD_EN
    localparam int SIDE = IW;
    localparam int OFF  = 1;
`else
    localparam int SIDE = IW - KS + 1;
    localparam int OFF  = 0;
`endif
    localparam int NWIN = SIDE * SIDE;
    localparam int WB   = KS * KS * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid_1 = 1'b0;
    logic          in_valid_2 = 1'b0;
    logic          win_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          win_valid, win_last, busy, err_proto;
    logic [WB-1:0] win_data, kern_data;
    logic [2:0]    win_row, win_col;
    int            vectors = 0;
    int            errors = 0;
    int            exp_n = 0;

    always #5 clk = ~clk;

    cnn_input_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_1 (in_valid_1),
        .in_valid_2 (in_valid_2),
        .in_data    (in_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .kern_data  (kern_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_last   (win_last),
        .busy       (busy),
        .err_proto  (err_proto)
    );

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Window n in raster order; pixel at (pr,pc) holds value pr*IW+pc, off-image taps are 0.
    function automatic logic [WB-1:0] model_win(input int n);
        logic [WB-1:0] w;
        int row;
        int col;
        int pr;
        int pc;
        w   = '0;
        row = n / SIDE;
        col = n % SIDE;
        for (int r = 0; r < KS; r++) begin
            for (int c = 0; c < KS; c++) begin
                pr = row + r - OFF;
                pc = col + c - OFF;
                if (pr >= 0 && pr < IW && pc >= 0 && pc < IW)
                    w[(r*KS+c)*DW +: DW] = DW'(pr * IW + pc);
            end
        end
        return w;
    endfunction

    function automatic logic [WB-1:0] model_kern();
        logic [WB-1:0] w;
        w = '0;
        for (int t = 0; t < KS * KS; t++) w[t*DW +: DW] = DW'(100 + t);
        return w;
    endfunction

    function automatic logic [WB-1:0] pack9(input int a[9]);
        logic [WB-1:0] w;
        w = '0;
        for (int t = 0; t < 9; t++) w[t*DW +: DW] = DW'(a[t]);
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n && win_valid) begin
            if (exp_n >= NWIN) begin
                vectors++;
                errors++;
                $display("FAIL extra_window: got window %0d, required at most %0d", exp_n, NWIN - 1);
            end else begin
                chk("model_win", win_data, model_win(exp_n));
                chk("model_kern", kern_data, model_kern());
                chk("model_row", WB'(win_row), WB'(exp_n / SIDE));
                chk("model_col", WB'(win_col), WB'(exp_n % SIDE));
                chk("model_last", WB'(win_last), WB'(exp_n == NWIN - 1));
                if (win_ready) exp_n++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v1, input logic v2, input int d);
        in_valid_1 = v1;
        in_valid_2 = v2;
        in_data    = DW'(d);
        tick();
        in_valid_1 = 1'b0;
        in_valid_2 = 1'b0;
    endtask

    task automatic load(input bit interleave, input bit errs);
        int  i = 0;
        int  j = 0;
        bit  turn = 1'b0;
        while (i < IW * IW || j < KS * KS) begin
            if (interleave) begin
                if ((turn || i >= IW * IW) && j < KS * KS) begin
                    beat(1'b0, 1'b1, 100 + j);
                    j++;
                end else begin
                    beat(1'b1, 1'b0, i);
                    i++;
                end
                turn = !turn;
                repeat ($urandom_range(0, 2)) tick();
            end else if (i < IW * IW) begin
                if (errs && i == 10) begin
                    beat(1'b1, 1'b1, 7);
                    chk("err_both_high", WB'(err_proto), WB'(1));
                end
                beat(1'b1, 1'b0, i);
                i++;
                if (errs && i == 11) chk("err_pulse_end", WB'(err_proto), WB'(0));
                if (errs && i == IW * IW) begin
                    beat(1'b1, 1'b0, 99);
                    chk("err_extra_pixel", WB'(err_proto), WB'(1));
                end
            end else begin
                beat(1'b0, 1'b1, 100 + j);
                j++;
            end
        end
    endtask

    task automatic wait_done(input string name);
        int cnt = 0;
        while (exp_n < NWIN && cnt < 500) begin
            tick();
            cnt++;
        end
        chk(name, WB'(exp_n), WB'(NWIN));
        chk("busy_after_last", WB'(busy), WB'(0));
        chk("valid_after_last", WB'(win_valid), WB'(0));
    endtask

    task automatic wait_window(input int n);
        int cnt = 0;
        while (!(win_valid && exp_n == n) && cnt < 500) begin
            tick();
            cnt++;
        end
        chk("reach_window", WB'(exp_n), WB'(n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required finish before 400000 ns");
        $fatal(1);
    end

    initial begin
        int lit[9];
        int cnt;
        #12;
        chk("rst_valid", WB'(win_valid), WB'(0));
        chk("rst_busy", WB'(busy), WB'(0));
        chk("rst_err", WB'(err_proto), WB'(0));
        chk("rst_last", WB'(win_last), WB'(0));
        chk("rst_pos", WB'({win_row, win_col}), WB'(0));
        chk("rst_win", win_data, '0);
        chk("rst_kern", kern_data, '0);
        rst_n = 1'b1;
        tick();

        // Basic load, full-rate stream.
        exp_n = 0;
        load(1'b0, 1'b0);
        chk("err_quiet", WB'(err_proto), WB'(0));
        chk("valid_latency_low", WB'(win_valid), WB'(0));
        chk("busy_load", WB'(busy), WB'(1));
        tick();
        chk("valid_rise", WB'(win_valid), WB'(1));
`ifdef CNN_LOADER_ZPAD_EN
        lit = '{0, 0, 0, 0, 0, 1, 0, 6, 7};
`else
        lit = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
`endif
        chk("first_win", win_data, pack9(lit));
        chk("first_pos", WB'({win_row, win_col}), WB'(0));
        lit = '{100, 101, 102, 103, 104, 105, 106, 107, 108};
        chk("kern_lit", kern_data, pack9(lit));
        cnt = 0;
        while (!win_last && cnt < 100) begin
            tick();
            cnt++;
        end
`ifdef CNN_LOADER_ZPAD_EN
        lit = '{28, 29, 0, 34, 35, 0, 0, 0, 0};
        chk("last_pos", WB'({win_row, win_col}), WB'({3'd5, 3'd5}));
`else
        lit = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
        chk("last_pos", WB'({win_row, win_col}), WB'({3'd3, 3'd3}));
`endif
        chk("last_win", win_data, pack9(lit));
        chk("last_flag", WB'(win_last), WB'(1));
        wait_done("basic_count");

        // Interleaved with gaps.
        exp_n = 0;
        load(1'b1, 1'b0);
        wait_done("interleave_count");

        // Backpressure on the (1,0) window.
        exp_n = 0;
        load(1'b0, 1'b0);
        wait_window(SIDE);
        win_ready = 1'b0;
        repeat (5) begin
            tick();
`ifndef CNN_LOADER_ZPAD_EN
            lit = '{6, 7, 8, 12, 13, 14, 18, 19, 20};
            chk("bp_hold_win", win_data, pack9(lit));
`endif
            chk("bp_hold_pos", WB'({win_row, win_col}), WB'({3'd1, 3'd0}));
            chk("bp_hold_valid", WB'(win_valid), WB'(1));
        end
        chk("bp_no_advance", WB'(exp_n), WB'(SIDE));
        win_ready = 1'b1;
        wait_done("bp_count");

        // Protocol errors in load and stream.
        exp_n = 0;
        load(1'b0, 1'b1);
        wait_window(3);
        beat(1'b1, 1'b0, 55);
        chk("err_in_stream", WB'(err_proto), WB'(1));
        tick();
        chk("err_stream_end", WB'(err_proto), WB'(0));
        wait_done("proto_count");

        // Asynchronous reset mid-stream, then a fresh load.
        exp_n = 0;
        load(1'b0, 1'b0);
        wait_window(8);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", WB'(win_valid), WB'(0));
        chk("mid_rst_busy", WB'(busy), WB'(0));
        chk("mid_rst_pos", WB'({win_row, win_col}), WB'(0));
        chk("mid_rst_win", win_data, '0);
        chk("mid_rst_kern", kern_data, '0);
        exp_n = 0;
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_idle", WB'(win_valid), WB'(0));
        load(1'b0, 1'b0);
        tick();
`ifdef CNN_LOADER_ZPAD_EN
        lit = '{0, 0, 0, 0, 0, 1, 0, 6, 7};
`else
        lit = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
`endif
        chk("reload_first_win", win_data, pack9(lit));
        wait_done("reset_count");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
